mips_reg_file: RTL and testbench
================================

Name: mips_reg_file

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath; directly upstream of the ALU.
- Read port 1 (rs) drives ALU in1. Read port 2 (rt) drives ALU in2 or the store-data path.
- One synchronous write port accepts the write-back result (ALU out or load data).
- Register $0 is hardwired to zero. $sp (r29) resets to a programmable value. A debug read port serves testbench and trace inspection.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- SP_INIT, 32'h0000_FFFC, reset value of r29 ($sp)
- BYPASS, 1, 1 = write-first forwarding on read ports; 0 = read returns stored value

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- rd_addr1  in  ADDR_W  read index, port 1 (rs)
- rd_data1  out  DATA_W  read data, port 1, to ALU in1
- rd_addr2  in  ADDR_W  read index, port 2 (rt)
- rd_data2  out  DATA_W  read data, port 2, to ALU in2 / store data
- wr_en  in  1  write enable (RegWrite)
- wr_addr  in  ADDR_W  write index (rd or rt, after RegDst mux)
- wr_data  in  DATA_W  write-back data
- dbg_addr  in  ADDR_W  debug read index
- dbg_data  out  DATA_W  debug read data (never bypassed)
- wr_count  out  32  count of committed writes to non-zero registers

Behaviour:
- Storage: registers 1..31 are flops. Register 0 has no storage; reads of index 0 return 0 on every port.
- Reset (rst=1, asynchronous):
  - All registers clear to 0, except r29 = SP_INIT.
  - wr_count = 0.
  - Writes are ignored while rst=1.
  - Read ports remain combinational during reset and return the reset contents.
  - Deassertion mid-cycle: the first write is taken at the first rising edge with rst=0.
- Write:
  - On rising clk with rst=0, wr_en=1 and wr_addr!=0: reg[wr_addr] <= wr_data, and wr_count increments by 1.
  - wr_en=1 with wr_addr=0: no state change and no count.
  - wr_count wraps from 2^32-1 to 0.
- Read, combinational, zero latency:
  - BYPASS=1 and rd_addrN==wr_addr and wr_en=1 and wr_addrN!=0 and rst=0: rd_dataN = wr_data. This is the same-cycle write-first value.
  - Otherwise rd_dataN = reg[rd_addrN], i.e. the value committed at the last edge.
  - BYPASS=0: the stored value always; the new value appears after the edge.
  - Both read ports may address the same register, or the write register, simultaneously. Each port resolves independently under the rules above.
- dbg_data = reg[dbg_addr] with no bypass; dbg_addr=0 returns 0.
- No X propagation: every output is defined from reset onward.
- Width rule: wr_data is stored verbatim. No sign handling here; signedness is interpreted downstream by the ALU.

Test Plan:
- Reset: pulse rst asynchronously between clock edges, no clock -> dbg_data=0 for every index except r29 = 32'h0000_FFFC; wr_count=0.
- Basic write/read:
  - Write r8=32'h1234_5678, then r9=32'hFFFF_FFF0 on consecutive edges.
  - Set rd_addr1=8, rd_addr2=9 -> rd_data1=32'h1234_5678, rd_data2=32'hFFFF_FFF0; wr_count=2.
- $zero: wr_en=1, wr_addr=0, wr_data=32'hDEAD_BEEF, clock -> rd_data1 with rd_addr1=0 reads 0 both before and after the edge; wr_count unchanged.
- Bypass:
  - r10 holds 5. Same cycle: wr_en=1, wr_addr=10, wr_data=7, rd_addr1=rd_addr2=10.
  - BYPASS=1 -> both read 7 before the edge. BYPASS=0 -> both read 5 before the edge and 7 after.
  - dbg_data reads 5 before the edge in either case.
- Reset mid-operation: after writing r8=3, assert rst while wr_en=1, wr_addr=8, wr_data=9, and hold across an edge -> r8=0, r29=SP_INIT, wr_count=0. After release with no write, r8 stays 0.
- Counter wrap: force wr_count near 2^32-1 (or run a reduced-width simulation), then perform writes -> count rolls to 0. Writes to r0 do not advance the count.

Source files
------------

// File: rtl/mips_reg_file.sv
// mips_reg_file
//   32-entry general-purpose register file for the single-cycle MIPS datapath.
//   Two combinational read ports feed the ALU (rs -> in1, rt -> in2 / store
//   data). One synchronous write port takes the write-back result. A debug
//   port reads stored contents without forwarding. r0 has no storage and
//   always reads as zero. r29 ($sp) resets to SP_INIT.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   rd_addr1/rd_data1   read port 1 (rs)
//   rd_addr2/rd_data2   read port 2 (rt)
//   wr_en/wr_addr/wr_data  write-back port (RegWrite, dest index, data)
//   dbg_addr/dbg_data   debug read port (stored value, never forwarded)
//   wr_count            committed writes to non-zero registers, wraps
//
// CNT_W sets the internal width of the write counter. It is zero-extended
// onto the 32-bit wr_count port, and its default gives the full 32-bit count.
module mips_reg_file #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 5,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h0000_FFFC),
  parameter bit                BYPASS  = 1'b1,
  parameter int unsigned       CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned SP_IDX = 29;

  // Index 0 is deliberately absent: it has no storage.
  logic [DATA_W-1:0] regs [1:DEPTH-1];
  logic [CNT_W-1:0]  cnt;
  logic              wr_hit;

  // A write commits only when not in reset and not targeting r0.
  assign wr_hit = !rst && wr_en && (wr_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
      cnt <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
      cnt           <= cnt + 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] a);
    return (a == '0) ? '0 : regs[a];
  endfunction

  // Each read port resolves forwarding independently of the other.
  always_comb begin
    rd_data1 = stored(rd_addr1);
    rd_data2 = stored(rd_addr2);
    if (BYPASS && wr_hit && (rd_addr1 == wr_addr)) rd_data1 = wr_data;
    if (BYPASS && wr_hit && (rd_addr2 == wr_addr)) rd_data2 = wr_data;
  end

  assign dbg_data = stored(dbg_addr);
  assign wr_count = 32'(cnt);

endmodule

// File: tb/tb_mips_reg_file.sv
`timescale 1ns/1ps
module tb_mips_reg_file;

  localparam logic [31:0] SP = 32'h0000_FFFC;

  logic        clk = 1'b0;
  bit          clk_on = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, dbg_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] a_rd1, a_rd2, a_dbg, a_cnt;  // BYPASS=1, full counter
  logic [31:0] b_rd1, b_rd2, b_dbg, b_cnt;  // BYPASS=0, 3-bit counter

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  always #5 if (clk_on) clk = ~clk;

  mips_reg_file #(.DATA_W(32), .ADDR_W(5), .SP_INIT(SP), .BYPASS(1'b1), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_data1(a_rd1),
    .rd_addr2(rd_addr2), .rd_data2(a_rd2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(a_dbg), .wr_count(a_cnt)
  );

  mips_reg_file #(.DATA_W(32), .ADDR_W(5), .SP_INIT(SP), .BYPASS(1'b0), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_data1(b_rd1),
    .rd_addr2(rd_addr2), .rd_data2(b_rd2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(b_dbg), .wr_count(b_cnt)
  );

  task automatic push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts as both DUTs see it: the BYPASS=0 instance carries a 3-bit counter.
  task automatic check_counts(input string tag);
    push({tag, "_cnt_a"}, 32'(exp_cnt));
    push({tag, "_cnt_b"}, 32'(exp_cnt % 8));
    cmp(a_cnt);
    cmp(b_cnt);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; dbg_addr = '0;

    // Asynchronous reset pulse with the clock stopped.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      push($sformatf("reset_dbg_a_r%0d", i), (i == 29) ? SP : 32'h0);
      push($sformatf("reset_dbg_b_r%0d", i), (i == 29) ? SP : 32'h0);
      cmp(a_dbg);
      cmp(b_dbg);
    end
    exp_cnt = 0;
    check_counts("reset");

    clk_on = 1'b1;

    // Basic writes on consecutive edges.
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h1234_5678;
    tick(); exp_cnt++;
    wr_addr = 5'd9; wr_data = 32'hFFFF_FFF0;
    tick(); exp_cnt++;
    wr_en = 1'b0; rd_addr1 = 5'd8; rd_addr2 = 5'd9;
    #1;
    push("basic_rd1_a", 32'h1234_5678); cmp(a_rd1);
    push("basic_rd2_a", 32'hFFFF_FFF0); cmp(a_rd2);
    push("basic_rd1_b", 32'h1234_5678); cmp(b_rd1);
    push("basic_rd2_b", 32'hFFFF_FFF0); cmp(b_rd2);
    check_counts("basic");

    // Writes to $zero neither store, forward, nor count.
    rd_addr1 = 5'd0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF;
    #1;
    push("zero_pre_a", 32'h0); cmp(a_rd1);
    push("zero_pre_b", 32'h0); cmp(b_rd1);
    tick();
    wr_en = 1'b0;
    #1;
    push("zero_post_a", 32'h0); cmp(a_rd1);
    push("zero_post_b", 32'h0); cmp(b_rd1);
    check_counts("zero");

    // Forwarding: r10 holds 5, same-cycle write of 7.
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'd5;
    tick(); exp_cnt++;
    wr_data = 32'd7; rd_addr1 = 5'd10; rd_addr2 = 5'd10; dbg_addr = 5'd10;
    #1;
    push("byp_pre_rd1_a", 32'd7); cmp(a_rd1);
    push("byp_pre_rd2_a", 32'd7); cmp(a_rd2);
    push("byp_pre_rd1_b", 32'd5); cmp(b_rd1);
    push("byp_pre_rd2_b", 32'd5); cmp(b_rd2);
    push("byp_pre_dbg_a", 32'd5); cmp(a_dbg);
    push("byp_pre_dbg_b", 32'd5); cmp(b_dbg);
    tick(); exp_cnt++;
    wr_en = 1'b0;
    #1;
    push("byp_post_rd1_a", 32'd7); cmp(a_rd1);
    push("byp_post_rd2_b", 32'd7); cmp(b_rd2);
    push("byp_post_dbg_b", 32'd7); cmp(b_dbg);
    check_counts("byp");

    // Ports resolve independently: only the port matching wr_addr forwards.
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h0000_00AA;
    rd_addr1 = 5'd8; rd_addr2 = 5'd9;
    #1;
    push("indep_rd1_a", 32'h0000_00AA); cmp(a_rd1);
    push("indep_rd2_a", 32'hFFFF_FFF0); cmp(a_rd2);
    push("indep_rd1_b", 32'h1234_5678); cmp(b_rd1);
    wr_en = 1'b0;

    // Reset in the middle of operation, with a write pending.
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'd3;
    tick(); exp_cnt++;
    wr_data = 32'd9; rst = 1'b1; dbg_addr = 5'd29;
    #1; exp_cnt = 0;
    push("rst_rd1_a", 32'h0); cmp(a_rd1);
    push("rst_rd1_b", 32'h0); cmp(b_rd1);
    push("rst_sp_a", SP);     cmp(a_dbg);
    check_counts("rst");
    tick();
    dbg_addr = 5'd8;
    #1;
    push("rst_edge_dbg_a", 32'h0); cmp(a_dbg);
    push("rst_edge_dbg_b", 32'h0); cmp(b_dbg);
    check_counts("rst_edge");
    wr_en = 1'b0;
    #2 rst = 1'b0;
    tick();
    push("rel_dbg_a", 32'h0); cmp(a_dbg);
    check_counts("rel");
    wr_en = 1'b1; wr_data = 32'd9;
    tick(); exp_cnt++;
    wr_en = 1'b0;
    #1;
    push("first_wr_dbg_a", 32'd9); cmp(a_dbg);
    push("first_wr_dbg_b", 32'd9); cmp(b_dbg);
    check_counts("first_wr");

    // Counter wrap on the 3-bit instance; r0 writes never advance the count.
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i * 16);
      tick(); exp_cnt++;
      wr_addr = 5'd0;
      tick();
      check_counts($sformatf("wrap_%0d", i));
    end
    wr_en = 1'b0;
    dbg_addr = 5'd8;
    #1;
    push("wrap_dbg_r8", 32'd128); cmp(a_dbg);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
